// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write output bundle for the UART command parser.
// master: upstream side (UART receiver / bench) that drives bytes and observes results.
// slave:  the parser itself.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        csum_err;
  logic        addr_err;
  logic        timeout_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, csum_err, addr_err, timeout_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, csum_err, addr_err, timeout_err, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Command frame parser: SYNC, ADDR, D3..D0 (big-endian), CSUM (XOR of the six
// preceding bytes). Good frames produce a single-cycle register write; bad
// checksum, out-of-range address or an inter-byte stall drop the frame with
// a single-cycle error pulse.
module uart_cmd_parser #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned TIMEOUT_CLKS = (CLK_FREQ / BAUD) * TIMEOUT_BITS;
  localparam int unsigned CNT_W        = 24;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

  // The stall counter is 24 bits; a longer timeout would silently wrap.
  generate
    if (TIMEOUT_CLKS >= (1 << CNT_W) || TIMEOUT_CLKS == 0) begin : g_bad_timeout
      $fatal(1, "uart_cmd_parser: TIMEOUT_CLKS must be in 1..2^24-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [7:0]       csum_reg, csum_next;
  logic [7:0]       addr_reg, addr_next;
  logic [31:0]      shift_reg, shift_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wr_en_reg, wr_en_next;
  logic [7:0]       wr_addr_reg, wr_addr_next;
  logic [31:0]      wr_data_reg, wr_data_next;
  logic             csum_err_reg, csum_err_next;
  logic             addr_err_reg, addr_err_next;
  logic             timeout_err_reg, timeout_err_next;

  // State and datapath registers; reset abandons any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_SYNC;
      idx_reg         <= '0;
      csum_reg        <= '0;
      addr_reg        <= '0;
      shift_reg       <= '0;
      cnt_reg         <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      csum_err_reg    <= 1'b0;
      addr_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      csum_reg        <= csum_next;
      addr_reg        <= addr_next;
      shift_reg       <= shift_next;
      cnt_reg         <= cnt_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      csum_err_reg    <= csum_err_next;
      addr_err_reg    <= addr_err_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Next-state logic: a received byte always takes priority over the stall
  // timeout, so a byte landing on the limit cycle is kept.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    csum_next        = csum_reg;
    addr_next        = addr_reg;
    shift_next       = shift_reg;
    cnt_next         = cnt_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    csum_err_next    = 1'b0;
    addr_err_next    = 1'b0;
    timeout_err_next = 1'b0;

    if (bus.rx_valid) begin
      cnt_next = '0;
      case (state_reg)
        S_SYNC: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_next = S_ADDR;
            csum_next  = SYNC_BYTE;
          end
        end
        S_ADDR: begin
          addr_next  = bus.rx_data;
          csum_next  = csum_reg ^ bus.rx_data;
          idx_next   = 2'd0;
          state_next = S_DATA;
        end
        S_DATA: begin
          shift_next = {shift_reg[23:0], bus.rx_data};
          csum_next  = csum_reg ^ bus.rx_data;
          if (idx_reg == 2'd3) begin
            state_next = S_CSUM;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
        S_CSUM: begin
          state_next = S_SYNC;
          if (bus.rx_data != csum_reg) begin
            csum_err_next = 1'b1;
          end else if (32'(addr_reg) >= NUM_REGS) begin
            addr_err_next = 1'b1;
          end else begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = shift_reg;
          end
        end
        default: state_next = S_SYNC;
      endcase
    end else if (state_reg != S_SYNC) begin
      if (cnt_reg == CNT_LIMIT) begin
        state_next       = S_SYNC;
        timeout_err_next = 1'b1;
        cnt_next         = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign bus.wr_en       = wr_en_reg;
  assign bus.wr_addr     = wr_addr_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.csum_err    = csum_err_reg;
  assign bus.addr_err    = addr_err_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.busy        = (state_reg != S_SYNC);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level reference model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_uart_cmd_parser;
  localparam int unsigned CLK_FREQ     = 1000;
  localparam int unsigned BAUD         = 100;
  localparam int unsigned TIMEOUT_BITS = 4;
  localparam int unsigned NUM_REGS     = 8;
  localparam logic [7:0]  SYNC         = 8'hA5;
  localparam int          LIM          = (CLK_FREQ / BAUD) * TIMEOUT_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TIMEOUT_BITS),
    .NUM_REGS(NUM_REGS), .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: collected frame bytes and idle cycles since last byte.
  logic [7:0]  frame [7];
  int          nbytes = 0;
  int          idle_cnt = 0;
  logic        m_wr_en = 1'b0, m_csum = 1'b0, m_addr = 1'b0, m_to = 1'b0;
  logic [7:0]  m_wr_addr = 8'h00;
  logic [31:0] m_wr_data = 32'h0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    logic [7:0] x;
    m_wr_en = 1'b0; m_csum = 1'b0; m_addr = 1'b0; m_to = 1'b0;
    if (rst) begin
      started   = 1'b1;
      nbytes    = 0;
      idle_cnt  = 0;
      m_wr_addr = 8'h00;
      m_wr_data = 32'h0;
    end else if (bus.rx_valid) begin
      idle_cnt = 0;
      if (nbytes == 0) begin
        if (bus.rx_data == SYNC) begin
          frame[0] = bus.rx_data;
          nbytes   = 1;
        end
      end else begin
        frame[nbytes] = bus.rx_data;
        nbytes = nbytes + 1;
        if (nbytes == 7) begin
          x = 8'h00;
          for (int i = 0; i < 6; i++) x = x ^ frame[i];
          if (x != frame[6]) m_csum = 1'b1;
          else if (int'(frame[1]) >= int'(NUM_REGS)) m_addr = 1'b1;
          else begin
            m_wr_en   = 1'b1;
            m_wr_addr = frame[1];
            m_wr_data = {frame[2], frame[3], frame[4], frame[5]};
          end
          nbytes = 0;
        end
      end
    end else if (nbytes != 0) begin
      idle_cnt = idle_cnt + 1;
      if (idle_cnt == LIM) begin
        m_to     = 1'b1;
        nbytes   = 0;
        idle_cnt = 0;
      end
    end
  end

  // DUT event log, captured from outputs.
  int          n_wr = 0, n_csum = 0, n_addr = 0, n_to = 0;
  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];

  // Per-cycle comparison against the model, plus event logging.
  always @(negedge clk) begin
    if (started) begin
      tests++;
      if ({bus.wr_en, bus.csum_err, bus.addr_err, bus.timeout_err, bus.busy, bus.wr_addr, bus.wr_data} !==
          {m_wr_en, m_csum, m_addr, m_to, (nbytes != 0), m_wr_addr, m_wr_data}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got we=%b ce=%b ae=%b te=%b busy=%b addr=%h data=%h, expected we=%b ce=%b ae=%b te=%b busy=%b addr=%h data=%h",
                 $time, bus.wr_en, bus.csum_err, bus.addr_err, bus.timeout_err, bus.busy, bus.wr_addr, bus.wr_data,
                 m_wr_en, m_csum, m_addr, m_to, (nbytes != 0), m_wr_addr, m_wr_data);
      end
      if (bus.wr_en === 1'b1) begin
        n_wr++;
        log_addr.push_back(bus.wr_addr);
        log_data.push_back(bus.wr_data);
        $display("[TB] t=%0t write addr=%h data=%h", $time, bus.wr_addr, bus.wr_data);
      end
      if (bus.csum_err === 1'b1) begin n_csum++; $display("[TB] t=%0t csum_err", $time); end
      if (bus.addr_err === 1'b1) begin n_addr++; $display("[TB] t=%0t addr_err", $time); end
      if (bus.timeout_err === 1'b1) begin n_to++; $display("[TB] t=%0t timeout_err", $time); end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] q [$];

  task automatic send_q();
    foreach (q[i]) send_byte(q[i]);
    idle(3);
  endtask

  int b_wr, b_csum, b_addr, b_to;

  task automatic snap();
    b_wr = n_wr; b_csum = n_csum; b_addr = n_addr; b_to = n_to;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_wr_addr", 32'(bus.wr_addr), 32'h0);
    check("reset_wr_data", bus.wr_data, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    idle(2);

    // Good frame
    snap();
    q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h82};
    send_q();
    check("good_wr_count", n_wr - b_wr, 1);
    check("good_addr", 32'(log_addr[b_wr]), 32'h01);
    check("good_data", log_data[b_wr], 32'h00001234);
    check("good_no_err", n_csum + n_addr + n_to - b_csum - b_addr - b_to, 0);

    // Bad checksum
    snap();
    q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h83};
    send_q();
    check("badcs_csum_err", n_csum - b_csum, 1);
    check("badcs_no_wr", n_wr - b_wr, 0);
    check("badcs_data_held", bus.wr_data, 32'h00001234);

    // Address out of range
    snap();
    q = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAD};
    send_q();
    check("addr_addr_err", n_addr - b_addr, 1);
    check("addr_no_wr", n_wr - b_wr, 0);
    check("addr_no_csum_err", n_csum - b_csum, 0);

    // Garbage then back-to-back frames on adjacent cycles
    snap();
    q = '{8'h00, 8'hFF, 8'h5A,
          8'hA5, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h82,
          8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h85};
    send_q();
    check("b2b_wr_count", n_wr - b_wr, 2);
    check("b2b_addr0", 32'(log_addr[b_wr]), 32'h01);
    check("b2b_data0", log_data[b_wr], 32'h00001234);
    check("b2b_addr1", 32'(log_addr[b_wr+1]), 32'h02);
    check("b2b_data1", log_data[b_wr+1], 32'hDEADBEEF);

    // Timeout after a stall of TIMEOUT_CLKS idle cycles
    snap();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    idle(LIM + 2);
    check("to_timeout_err", n_to - b_to, 1);
    check("to_busy", 32'(bus.busy), 32'h0);
    check("to_no_wr", n_wr - b_wr, 0);
    snap();
    q = '{8'hA5, 8'h05, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h69};
    send_q();
    check("after_to_wr", n_wr - b_wr, 1);
    check("after_to_data", log_data[b_wr], 32'hCAFEF00D);

    // Byte arriving exactly on the limit cycle is kept
    snap();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    idle(LIM - 1);
    q = '{8'h22, 8'h33, 8'h44, 8'hE2};
    send_q();
    check("limit_no_timeout", n_to - b_to, 0);
    check("limit_wr", n_wr - b_wr, 1);
    check("limit_addr", 32'(log_addr[b_wr]), 32'h03);
    check("limit_data", log_data[b_wr], 32'h11223344);

    // Reset mid-frame
    snap();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_wr_data", bus.wr_data, 32'h0);
    idle(2);
    check("rst_no_err", n_csum + n_addr + n_to - b_csum - b_addr - b_to, 0);
    q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h82};
    send_q();
    check("rst_wr", n_wr - b_wr, 1);
    check("rst_data", log_data[b_wr], 32'h00001234);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame parser sitting directly downstream of the UART receiver in the motor-control design. Consumes the receiver's byte stream (8-bit data plus single-cycle valid strobe), assembles fixed-length command frames, validates the checksum and address range, and issues single-cycle register-write strobes to the PID/motor register bank. Malformed, stalled or out-of-range frames are dropped and flagged; they produce no write.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART baud rate; sets the inter-byte timeout
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods; TIMEOUT_CLKS = (CLK_FREQ/BAUD)*TIMEOUT_BITS
- NUM_REGS, 8, number of writable registers; valid addresses are 0..NUM_REGS-1
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte; sampled only when rx_valid=1
- rx_valid  in  1  single-cycle byte strobe
- wr_en  out  1  single-cycle register-write strobe
- wr_addr  out  8  register address; held until the next write
- wr_data  out  32  register value; held until the next write
- csum_err  out  1  single-cycle pulse: checksum mismatch
- addr_err  out  1  single-cycle pulse: good checksum, address >= NUM_REGS
- timeout_err  out  1  single-cycle pulse: frame abandoned on inter-byte timeout
- busy  out  1  high whenever state != SYNC

## Operation
- Frame is 7 bytes: SYNC_BYTE, ADDR, D3, D2, D1, D0, CSUM. Data is big-endian: wr_data = {D3,D2,D1,D0}.
- CSUM = SYNC_BYTE ^ ADDR ^ D3 ^ D2 ^ D1 ^ D0, an 8-bit XOR.
- States: SYNC, ADDR, DATA (2-bit byte index 0..3), CSUM.
- SYNC: any byte other than SYNC_BYTE is discarded silently. SYNC_BYTE moves to ADDR and seeds the running XOR with SYNC_BYTE.
- ADDR: latch the address, XOR it into the running checksum, go to DATA with index 0.
- DATA: shift the byte into a 32-bit shift register (MSB first) and XOR it into the checksum. Index 3 moves to CSUM; otherwise increment the index.
- CSUM: always return to SYNC.
  - Byte != running XOR: csum_err.
  - Byte matches and ADDR >= NUM_REGS: addr_err.
  - Otherwise: wr_en, and wr_addr/wr_data are updated.
- SYNC_BYTE appearing in ADDR, DATA or CSUM positions is treated as ordinary data. There is no mid-frame resync.
- Timeout: a counter runs while state != SYNC.
  - It clears on every rx_valid.
  - On reaching TIMEOUT_CLKS-1, go to SYNC and pulse timeout_err.
  - If rx_valid arrives in the same cycle the counter hits its limit, rx_valid wins: the byte is processed and the counter clears.
- The counter is 24 bits wide. An elaboration-time check requires TIMEOUT_CLKS < 2^24.
- rx_valid asserted on consecutive cycles is accepted; every strobe is one byte.

## Timing
- Reset values: state=SYNC, wr_en=0, wr_addr=0, wr_data=0, csum_err=0, addr_err=0, timeout_err=0, busy=0. Checksum, index and counter are cleared.
- Reset asserted mid-frame discards the partial frame with no error pulse. The first rx_valid after reset release is processed normally.
- wr_en, csum_err and addr_err rise on the cycle after the rx_valid that carries CSUM. Exactly one of the three fires per completed frame.
- wr_addr and wr_data change in the same cycle wr_en rises and are stable at least until the next wr_en.
- All pulse outputs are registered, high for exactly one cycle, and never overlap.
- busy rises the cycle after the SYNC_BYTE strobe. It falls the cycle after the CSUM strobe, or the cycle after the timeout fires.
- A new SYNC_BYTE is accepted on the cycle immediately after the CSUM strobe. The parser needs no gap between frames.

## Test plan
- Good frame: send A5 01 00 00 12 34 82 -> one wr_en pulse, wr_addr=0x01, wr_data=0x00001234; no error pulses.
- Bad checksum: send A5 01 00 00 12 34 83 -> csum_err for one cycle, no wr_en; wr_data keeps its previous value.
- Address out of range: send A5 08 00 00 00 00 AD (NUM_REGS=8) -> addr_err only, no wr_en.
- Garbage and back-to-back frames:
  - Send 00 FF 5A, then the good frame, then immediately A5 02 DE AD BE EF (csum 0xA5^0x02^0x22 = 0x85) with rx_valid on adjacent cycles.
  - Required response: two wr_en pulses, (0x01, 0x00001234) then (0x02, 0xDEADBEEF).
- Timeout:
  - Send A5 03 11, then idle TIMEOUT_CLKS cycles -> timeout_err, busy=0, no wr_en. A following good frame is written correctly.
  - A byte arriving exactly on the limit cycle is accepted, and no timeout fires.
- Reset mid-frame: send A5 01 00, pulse rst for 1 cycle, send the good frame -> outputs return to reset values, no error pulses, then one wr_en with 0x00001234.
